// File: rtl/mux_nto1_rr_reg.sv
// Registered N-channel mux with manual-select or round-robin scan over valid channels.
// The output word uses a valid/ready handshake; grant_out flags the channel captured this cycle.
module mux_nto1_rr_reg #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_CH*DATA_W-1:0] d_in,
  input  logic [NUM_CH-1:0]        ch_valid_in,
  input  logic                     mode_in,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     ready_in,
  output logic [DATA_W-1:0]        y_out,
  output logic                     y_valid_out,
  output logic [SEL_W-1:0]         ch_out,
  output logic [NUM_CH-1:0]        grant_out
);

  logic [DATA_W-1:0]   ch_data [NUM_CH];
  logic [SEL_W-1:0]    ptr_reg;
  logic [SEL_W-1:0]    ptr_next;
  logic                slot_free;
  logic                man_hit;
  logic                scan_hit;
  logic [SEL_W-1:0]    scan_idx;
  logic                capture;
  logic [SEL_W-1:0]    cap_idx;
  logic [2*NUM_CH-1:0] valid_dbl;
  logic [NUM_CH-1:0]   valid_rot;
  int                  pos;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = d_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    slot_free = !y_valid_out || ready_in;

    // Manual hit: compare against every real channel index so out-of-range selects never match.
    man_hit = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_in == SEL_W'(k) && ch_valid_in[k]) man_hit = 1'b1;
    end

    // Rotate the valid vector so bit i corresponds to channel (ptr + i) mod NUM_CH.
    valid_dbl = {ch_valid_in, ch_valid_in} >> ptr_reg;
    valid_rot = valid_dbl[NUM_CH-1:0];
    scan_hit  = 1'b0;
    scan_idx  = '0;
    pos       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!scan_hit && valid_rot[i]) begin
        scan_hit = 1'b1;
        pos      = int'(ptr_reg) + i;
        if (pos >= NUM_CH) pos = pos - NUM_CH;
        scan_idx = SEL_W'(pos);
      end
    end

    capture = slot_free && (mode_in ? scan_hit : man_hit);
    cap_idx = mode_in ? scan_idx : sel_in;

    grant_out = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      grant_out[k] = rst_n_in && capture && (cap_idx == SEL_W'(k));
    end

    ptr_next = ptr_reg;
    if (capture && mode_in) begin
      ptr_next = (scan_idx == SEL_W'(NUM_CH - 1)) ? '0 : scan_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_out       <= '0;
      y_valid_out <= 1'b0;
      ch_out      <= '0;
      ptr_reg     <= '0;
    end else begin
      ptr_reg <= ptr_next;
      if (slot_free) begin
        if (capture) begin
          y_out       <= ch_data[cap_idx];
          ch_out      <= cap_idx;
          y_valid_out <= 1'b1;
        end else begin
          y_valid_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr_reg.sv
// Bench for mux_nto1_rr_reg: per-cycle comparison against a behavioural model
// plus directed literal expectations for manual, scan, backpressure, reset and wrap cases.
module tb_mux_nto1_rr_reg;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b1;
  logic [N*W-1:0]  d;
  logic [N-1:0]    v;
  logic            mode;
  logic [SW-1:0]   sel;
  logic            ready;
  logic [W-1:0]    y;
  logic            y_valid;
  logic [SW-1:0]   ch;
  logic [N-1:0]    grant;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  logic [W-1:0] m_y = '0;
  bit           m_valid = 1'b0;
  int           m_ch = 0;
  int           m_ptr = 0;

  mux_nto1_rr_reg #(.NUM_CH(N), .DATA_W(W)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .d_in(d), .ch_valid_in(v), .mode_in(mode),
    .sel_in(sel), .ready_in(ready), .y_out(y), .y_valid_out(y_valid),
    .ch_out(ch), .grant_out(grant)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Which channel the rules say is captured this cycle, or -1.
  function automatic int pick();
    if (rst_n !== 1'b1) return -1;
    if (m_valid && !ready) return -1;
    if (!mode) return (int'(sel) < N && v[sel]) ? int'(sel) : -1;
    for (int i = 0; i < N; i++) begin
      if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y = '0; m_valid = 1'b0; m_ch = 0; m_ptr = 0;
    end else begin
      int p;
      p = pick();
      if (!m_valid || ready) begin
        if (p >= 0) begin
          m_y = d[p*W +: W];
          m_ch = p;
          m_valid = 1'b1;
          if (mode) m_ptr = (p + 1) % N;
          $display("capture ch=%0d data=%h mode=%0d", p, m_y, mode);
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      int p;
      p = pick();
      chk("model_grant", 32'(grant), (p >= 0) ? (32'd1 << p) : 32'd0);
      chk("model_y", 32'(y), 32'(m_y));
      chk("model_valid", 32'(y_valid), 32'(m_valid));
      chk("model_ch", 32'(ch), 32'(m_ch));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct { bit md; int s; logic [N-1:0] vv; bit rd; } vec_t;
  vec_t tbl [8];
  int rr_exp [6];

  initial begin
    for (int k = 0; k < N; k++) d[k*W +: W] = W'(8'h10 + k);
    v = '0; mode = 1'b0; sel = '0; ready = 1'b0;
    #2 rst_n = 1'b0;
    checking = 1'b1;
    tick(); tick();
    chk("reset_valid", 32'(y_valid), 0);
    chk("reset_y", 32'(y), 0);
    chk("reset_ch", 32'(ch), 0);
    rst_n = 1'b1;

    // Manual sweep
    mode = 1'b0; v = 8'hFF; ready = 1'b1;
    for (int s = 0; s < N; s++) begin
      sel = SW'(s);
      #2 chk("man_grant", 32'(grant), 32'd1 << s);
      tick();
      chk("man_y", 32'(y), 32'h10 + s);
      chk("man_ch", 32'(ch), s);
      chk("man_valid", 32'(y_valid), 1);
    end

    // Manual select of an invalid channel
    sel = 3'd3; v = 8'hF7;
    #2 chk("inv_grant", 32'(grant), 0);
    tick();
    chk("inv_valid", 32'(y_valid), 0);
    chk("inv_y", 32'(y), 32'h17);
    chk("inv_ch", 32'(ch), 7);

    // Round-robin over channels 2,5,7; channel 5 dropped after its first grant
    mode = 1'b1; v = 8'hA4;
    rr_exp = '{2, 5, 7, 2, 7, 2};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_ch", 32'(ch), rr_exp[i]);
      chk("rr_y", 32'(y), 32'h10 + rr_exp[i]);
      if (i == 1) v = 8'h84;
    end

    // Reset with a word pending, checked without a clock edge
    v = 8'hFF;
    rst_n = 1'b0;
    #1;
    chk("async_y", 32'(y), 0);
    chk("async_valid", 32'(y_valid), 0);
    chk("async_ch", 32'(ch), 0);
    chk("async_grant", 32'(grant), 0);
    tick();
    rst_n = 1'b1;

    // Backpressure: capture ch0, stall three cycles, resume with ch1
    tick();
    chk("bp_first_ch", 32'(ch), 0);
    chk("bp_first_y", 32'(y), 32'h10);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("bp_stall_grant", 32'(grant), 0);
      tick();
      chk("bp_stall_y", 32'(y), 32'h10);
      chk("bp_stall_valid", 32'(y_valid), 1);
    end
    ready = 1'b1;
    #2 chk("bp_resume_grant", 32'(grant), 32'h02);
    tick();
    chk("bp_resume_y", 32'(y), 32'h11);
    chk("bp_resume_valid", 32'(y_valid), 1);

    // Scan up to channel 6, two manual words, then scan resumes at 7 and wraps to 0
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk("wrap_scan_ch", 32'(ch), k);
    end
    mode = 1'b0; sel = 3'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wrap_man_ch", 32'(ch), 0);
      chk("wrap_man_y", 32'(y), 32'h10);
    end
    mode = 1'b1;
    tick();
    chk("wrap_ch7", 32'(ch), 7);
    tick();
    chk("wrap_ch0", 32'(ch), 0);

    // Mixed vectors checked by the model only
    tbl = '{'{1, 0, 8'h11, 1}, '{1, 0, 8'h11, 0}, '{1, 0, 8'h00, 1}, '{0, 6, 8'h40, 0},
            '{0, 6, 8'h40, 1}, '{1, 2, 8'h81, 1}, '{0, 1, 8'h01, 1}, '{1, 0, 8'h81, 1}};
    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].md; sel = SW'(tbl[i].s); v = tbl[i].vv; ready = tbl[i].rd;
      tick();
    end
    ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
